// File: rtl/risc24_run_controller_if.sv
// risc24_run_controller_if: control/status bundle between the run controller and its driver
interface risc24_run_controller_if #(
  parameter int CNT_W = 16
) ();
  logic             start;
  logic             step_mode;
  logic             step_req;
  logic             halt_in;
  logic             core_reset;
  logic             core_clk_en;
  logic [CNT_W-1:0] cycle_count;
  logic             running;
  logic             step_ack;
  logic             done;
  logic             timeout;
  modport master (
    output start, step_mode, step_req, halt_in,
    input  core_reset, core_clk_en, cycle_count, running, step_ack, done, timeout
  );
  modport slave (
    input  start, step_mode, step_req, halt_in,
    output core_reset, core_clk_en, cycle_count, running, step_ack, done, timeout
  );
endinterface

// File: rtl/risc24_run_controller.sv
// risc24_run_controller: reset hold, free-run/single-step clock gating and cycle budget for the RISC24 core
module risc24_run_controller #(
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 60,
  parameter int CNT_W        = 16
) (
  input logic clk,
  input logic reset,
  risc24_run_controller_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RESET_HOLD, RUN, STEP_WAIT, STEP_EXEC, DONE, TIMEOUT} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d, cnt_q, cnt_d, inc;
  logic             req_q;
  logic             core_reset_q, core_reset_d, clk_en_q, clk_en_d, running_q, running_d;
  logic             ack_q, ack_d, done_q, done_d, timeout_q, timeout_d;
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    inc     = cnt_q + CNT_W'(1);
    case (state_q)
      IDLE, DONE, TIMEOUT: if (bus.start) begin
        state_d = RESET_HOLD;
        hold_d  = '0;
        cnt_d   = '0;
      end
      RESET_HOLD: begin
        hold_d = hold_q + CNT_W'(1);
        if (hold_q == CNT_W'(RESET_CYCLES - 1)) state_d = bus.step_mode ? STEP_WAIT : RUN;
      end
      RUN, STEP_EXEC: if (bus.halt_in) state_d = DONE;
      else begin
        cnt_d   = inc;
        state_d = (inc == CNT_W'(MAX_CYCLES)) ? TIMEOUT
                : (state_q == STEP_EXEC || bus.step_mode) ? STEP_WAIT : RUN;
      end
      STEP_WAIT: state_d = bus.halt_in ? DONE : !bus.step_mode ? RUN
                         : (bus.step_req && !req_q) ? STEP_EXEC : STEP_WAIT;
      default: state_d = IDLE;
    endcase
    // outputs are registered copies of the next state's decode
    core_reset_d = state_d == IDLE || state_d == RESET_HOLD;
    clk_en_d     = state_d == RUN || state_d == STEP_EXEC;
    running_d    = state_d == RUN;
    ack_d        = state_d == STEP_EXEC;
    done_d       = state_d == DONE;
    timeout_d    = state_d == TIMEOUT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      cnt_q        <= '0;
      req_q        <= 1'b0;
      core_reset_q <= 1'b1;
      clk_en_q     <= 1'b0;
      running_q    <= 1'b0;
      ack_q        <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      cnt_q        <= cnt_d;
      req_q        <= bus.step_req;
      core_reset_q <= core_reset_d;
      clk_en_q     <= clk_en_d;
      running_q    <= running_d;
      ack_q        <= ack_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
    end
  end
  assign bus.core_reset  = core_reset_q;
  assign bus.core_clk_en = clk_en_q;
  assign bus.cycle_count = cnt_q;
  assign bus.running     = running_q;
  assign bus.step_ack    = ack_q;
  assign bus.done        = done_q;
  assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_risc24_run_controller.sv
// tb_risc24_run_controller: directed checks of reset hold, free-run, timeout, single-step, mode switch and abort
module tb_risc24_run_controller;
  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   acks, ens, consec;
  logic prev_ack;
  risc24_run_controller_if #(.CNT_W(16)) bus ();
  risc24_run_controller #(.RESET_CYCLES(2), .MAX_CYCLES(60), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick_acc();
    tick();
    acks += int'(bus.step_ack);
    ens  += int'(bus.core_clk_en);
    if (bus.step_ack && prev_ack) consec++;
    prev_ack = bus.step_ack;
  endtask
  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.step_mode = 1'b0; bus.step_req = 1'b0; bus.halt_in = 1'b0;
    tick(2);
    chk("rst_core_reset", int'(bus.core_reset), 1);
    chk("rst_clk_en", int'(bus.core_clk_en), 0);
    chk("rst_count", int'(bus.cycle_count), 0);
    chk("rst_running", int'(bus.running), 0);
    chk("rst_ack", int'(bus.step_ack), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_timeout", int'(bus.timeout), 0);
    reset = 1'b0;
    tick();
    chk("idle_core_reset", int'(bus.core_reset), 1);
    // free run with halt in the 20th RUN cycle
    do_start();
    chk("hold1_core_reset", int'(bus.core_reset), 1);
    chk("hold1_clk_en", int'(bus.core_clk_en), 0);
    tick();
    chk("hold2_core_reset", int'(bus.core_reset), 1);
    tick();
    chk("run_core_reset", int'(bus.core_reset), 0);
    chk("run_running", int'(bus.running), 1);
    chk("run_clk_en", int'(bus.core_clk_en), 1);
    chk("run_count0", int'(bus.cycle_count), 0);
    tick(19);
    chk("run_count19", int'(bus.cycle_count), 19);
    bus.halt_in = 1'b1;
    tick();
    bus.halt_in = 1'b0;
    chk("halt_done", int'(bus.done), 1);
    chk("halt_count", int'(bus.cycle_count), 19);
    chk("halt_clk_en", int'(bus.core_clk_en), 0);
    chk("halt_core_reset", int'(bus.core_reset), 0);
    tick(3);
    chk("done_frozen_count", int'(bus.cycle_count), 19);
    chk("done_sticky", int'(bus.done), 1);
    // restart from DONE, then run to timeout
    do_start();
    chk("restart_done_clr", int'(bus.done), 0);
    chk("restart_count_clr", int'(bus.cycle_count), 0);
    chk("restart_core_reset", int'(bus.core_reset), 1);
    tick(2);
    tick(59);
    chk("to_pre_count", int'(bus.cycle_count), 59);
    chk("to_pre_running", int'(bus.running), 1);
    tick();
    chk("to_timeout", int'(bus.timeout), 1);
    chk("to_done", int'(bus.done), 0);
    chk("to_count", int'(bus.cycle_count), 60);
    chk("to_clk_en", int'(bus.core_clk_en), 0);
    tick(2);
    chk("to_frozen", int'(bus.cycle_count), 60);
    // halt and budget collide in the 60th cycle; start mid-run is ignored
    do_start();
    chk("coll_timeout_clr", int'(bus.timeout), 0);
    tick(2);
    tick(30);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("run_start_ignored", int'(bus.cycle_count), 31);
    chk("run_start_running", int'(bus.running), 1);
    tick(28);
    chk("coll_pre_count", int'(bus.cycle_count), 59);
    bus.halt_in = 1'b1;
    tick();
    bus.halt_in = 1'b0;
    chk("coll_done", int'(bus.done), 1);
    chk("coll_timeout", int'(bus.timeout), 0);
    chk("coll_count", int'(bus.cycle_count), 59);
    // single step: one held request then three pulses
    bus.step_mode = 1'b1;
    do_start();
    tick(2);
    chk("sw_running", int'(bus.running), 0);
    chk("sw_clk_en", int'(bus.core_clk_en), 0);
    chk("sw_core_reset", int'(bus.core_reset), 0);
    chk("sw_count", int'(bus.cycle_count), 0);
    acks = 0; ens = 0; consec = 0; prev_ack = 1'b0;
    bus.step_req = 1'b1;
    for (int i = 0; i < 5; i++) tick_acc();
    bus.step_req = 1'b0;
    tick_acc();
    for (int i = 0; i < 3; i++) begin
      bus.step_req = 1'b1;
      tick_acc();
      bus.step_req = 1'b0;
      tick_acc();
      tick_acc();
    end
    chk("step_acks", acks, 4);
    chk("step_clk_en_pulses", ens, 4);
    chk("step_ack_one_cycle", consec, 0);
    chk("step_count", int'(bus.cycle_count), 4);
    // mode switch STEP_WAIT -> RUN -> STEP_WAIT
    bus.step_mode = 1'b0;
    tick();
    chk("ms_running", int'(bus.running), 1);
    chk("ms_count_run", int'(bus.cycle_count), 4);
    tick(3);
    chk("ms_count7", int'(bus.cycle_count), 7);
    bus.step_mode = 1'b1;
    tick();
    chk("ms_back_running", int'(bus.running), 0);
    chk("ms_back_clk_en", int'(bus.core_clk_en), 0);
    chk("ms_back_count", int'(bus.cycle_count), 8);
    bus.halt_in = 1'b1;
    tick();
    bus.halt_in = 1'b0;
    chk("sw_halt_done", int'(bus.done), 1);
    chk("sw_halt_count", int'(bus.cycle_count), 8);
    // abort mid-run with reset overriding start
    bus.step_mode = 1'b0;
    do_start();
    tick(2);
    tick(30);
    chk("abort_pre_count", int'(bus.cycle_count), 30);
    reset = 1'b1;
    bus.start = 1'b1;
    tick();
    chk("abort_core_reset", int'(bus.core_reset), 1);
    chk("abort_count", int'(bus.cycle_count), 0);
    chk("abort_running", int'(bus.running), 0);
    chk("abort_clk_en", int'(bus.core_clk_en), 0);
    reset = 1'b0;
    bus.start = 1'b0;
    tick(3);
    chk("abort_idle_core_reset", int'(bus.core_reset), 1);
    chk("abort_idle_running", int'(bus.running), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/risc24_run_controller.md
Name: risc24_run_controller

Overview:
- Synthesisable run controller for the multicycle RISC24 core; replaces hand-timed reset/finish sequencing with a parametrised, checkable FSM.
- Holds the core in reset for a programmable number of cycles, then gates the core clock enable in free-run or single-step mode.
- Counts executed cycles and terminates on core halt or on a cycle-budget timeout.
- Sits between the top-level clock/reset and the core's reset and clock-enable inputs; its status outputs feed benches and debug logic.

Parameters:
- RESET_CYCLES, 2, number of cycles core_reset is held high after a start; must be >= 1.
- MAX_CYCLES, 60, cycle budget; reaching it without a halt gives a timeout. Must satisfy 1 <= MAX_CYCLES < 2**CNT_W.
- CNT_W, 16, width of cycle_count and the internal hold counter.

Ports:
- clk  in  1  system clock; every register updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to (re)start a run.
- step_mode  in  1  1 selects single-step mode, 0 selects free-run mode.
- step_req  in  1  step request; rising-edge qualified.
- halt_in  in  1  halt indication from the core.
- core_reset  out  1  reset to the core.
- core_clk_en  out  1  clock enable to the core.
- cycle_count  out  CNT_W  number of core cycles executed in the current run.
- running  out  1  high while in RUN.
- step_ack  out  1  one-cycle pulse for each executed step.
- done  out  1  run ended by halt; sticky.
- timeout  out  1  run ended by budget exhaustion; sticky.

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-high.
- Reset response, applied at the first clk edge with reset=1:
  - state goes to IDLE.
  - core_reset=1, core_clk_en=0, cycle_count=0.
  - running=0, step_ack=0, done=0, timeout=0.
  - step_req edge register cleared.
- Reset asserted mid-run aborts the run immediately with the same values. It overrides start.
- All outputs are registered; each output reflects the current state.
- IDLE:
  - core_reset=1.
  - start=1 → RESET_HOLD; hold counter and cycle_count cleared.
- RESET_HOLD:
  - core_reset=1 and core_clk_en=0 for exactly RESET_CYCLES cycles.
  - Then → RUN if step_mode=0, else → STEP_WAIT.
  - core_reset=0 from the first cycle after RESET_HOLD.
- RUN:
  - core_clk_en=1, running=1.
  - halt_in=1 → DONE; cycle_count is not incremented in that cycle.
  - Otherwise cycle_count increments. If the new value equals MAX_CYCLES → TIMEOUT.
  - Halt has priority over timeout in the same cycle.
  - Else if step_mode=1 → STEP_WAIT.
- STEP_WAIT:
  - core_clk_en=0.
  - Priority: halt_in=1 → DONE; else step_mode=0 → RUN; else rising edge of step_req → STEP_EXEC.
  - Rising edge means step_req=1 now and step_req=0 in the previous cycle.
  - A held step_req produces exactly one step.
- STEP_EXEC:
  - Lasts exactly one cycle: core_clk_en=1, step_ack=1.
  - cycle_count increments, then → STEP_WAIT.
  - Same halt/timeout checks as RUN; halt wins.
- DONE / TIMEOUT:
  - core_clk_en=0, core_reset=0, so core state stays observable.
  - cycle_count frozen; done or timeout held at 1.
  - start=1 → RESET_HOLD, clearing done, timeout and cycle_count.
- start is ignored in RESET_HOLD, RUN, STEP_WAIT and STEP_EXEC.
- cycle_count never exceeds MAX_CYCLES and never wraps.

Test Plan:
- Reset and free-run:
  - Stimulus: reset 2 cycles, start pulse, step_mode=0, halt_in rises on the 20th RUN cycle.
  - Required: core_reset=1 for exactly 2 cycles after start; done=1, cycle_count=19, core_clk_en=0 thereafter.
- Timeout:
  - Stimulus: MAX_CYCLES=60, halt_in held 0.
  - Required: TIMEOUT after 60 RUN cycles; cycle_count=60, timeout=1, done=0.
- Halt/timeout collision:
  - Stimulus: halt_in=1 in the 60th RUN cycle.
  - Required: done=1, timeout=0, cycle_count=59.
- Single step:
  - Stimulus: step_mode=1, step_req held high 5 cycles, then 3 separate pulses.
  - Required: exactly 4 step_ack pulses, 4 one-cycle core_clk_en pulses, cycle_count=4.
- Mode switch:
  - Stimulus: step_mode 1→0 in STEP_WAIT, then 0→1 mid-RUN.
  - Required: RUN resumes next cycle; return to STEP_WAIT with counting continuous.
- Abort and restart:
  - Stimulus: reset mid-RUN with cycle_count=30.
  - Required: next edge gives IDLE, cycle_count=0, core_reset=1.
  - Follow-up: start in DONE re-enters RESET_HOLD with flags cleared.
